// File: rtl/matrix_mem_responder_pkg.sv
// matrix_mem_responder_pkg
// Shared definitions for the matrix-multiply scratchpad responder:
//   - mem_operation encodings seen on the engine port
//   - default word width (`TYPE_BW)
//   - offsets of the four parameter words at the bottom of memory
//   - FSM state type, exported on the debug port of the responder
// No ports; imported by the interface, the RAM and the top.

`ifndef TYPE_BW
`define TYPE_BW 32
`endif

package matrix_mem_responder_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b11;

  localparam int TYPE_BW = `TYPE_BW;

  // Operand descriptor words preloaded by the host ahead of A and B.
  localparam int PARAM_WIDTH_A  = 0;
  localparam int PARAM_HEIGHT_A = 1;
  localparam int PARAM_WIDTH_B  = 2;
  localparam int PARAM_HEIGHT_B = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  // 2'b10 is reserved and behaves exactly like MEM_NONE.
  function automatic logic is_request(input logic [1:0] op);
    return (op == MEM_READ) || (op == MEM_WRITE);
  endfunction

endpackage

// File: rtl/matrix_mem_responder_if.sv
// matrix_mem_responder_if
// Engine-side memory bus between the matrix-multiply engine (master) and the
// scratchpad responder (slave).
//
// Handshake: the master presents mem_operation/addr_i/data_i and keeps them
// stable; the slave accepts when idle (or when the tuple changes after a
// completion), asserts busy from the accept cycle through completion, and
// pulses mem_opdone for exactly one cycle with data_o valid in that same
// cycle. A given (op, addr) tuple is served once; to repeat it, the master
// drives mem_operation = none for at least one cycle in between.
//
// Signals:
//   mem_operation  master->slave  2'b00 none, 01 read, 11 write, 10 none
//   addr_i         master->slave  32-bit word address
//   data_i         master->slave  write data
//   data_o         slave->master  read data, valid with mem_opdone
//   mem_opdone     slave->master  single-cycle completion pulse
//   busy           slave->master  request in flight

interface matrix_mem_responder_if #(
  parameter int DATA_W = `TYPE_BW
) ();

  logic [1:0]        mem_operation;
  logic [31:0]       addr_i;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;
  logic              mem_opdone;
  logic              busy;

  modport master (
    output mem_operation, addr_i, data_i,
    input  data_o, mem_opdone, busy
  );

  modport slave (
    input  mem_operation, addr_i, data_i,
    output data_o, mem_opdone, busy
  );

endinterface

// File: rtl/matrix_mem_responder_dual_port_ram.sv
// dual_port_ram
// Two-port word RAM behind the responder. Both ports have registered reads
// and synchronous writes. Reads return the value held before a same-edge
// write (read-before-write). If both ports write the same address on the
// same edge, port A wins and port B's write is discarded; collision_o flags
// that case combinationally. Memory contents are never reset; only the read
// data registers are.
//
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   a_en_i/a_we_i/a_addr_i/a_wdata_i  port A (engine) access
//   a_rdata_o                         port A registered read data
//   b_en_i/b_we_i/b_addr_i/b_wdata_i  port B (host) access
//   b_rdata_o                         port B registered read data
//   collision_o                       port B write being dropped this cycle

module dual_port_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_en_i,
  input  logic              a_we_i,
  input  logic [AW-1:0]     a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_en_i,
  input  logic              b_we_i,
  input  logic [AW-1:0]     b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              collision_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;
  logic              a_wr;
  logic              b_wr;

  assign a_wr        = a_en_i && a_we_i;
  assign collision_o = a_wr && b_en_i && b_we_i && (a_addr_i == b_addr_i);
  assign b_wr        = b_en_i && b_we_i && !collision_o;

  always_ff @(posedge clk) begin
    if (a_wr) begin
      mem_q[a_addr_i] <= a_wdata_i;
    end
    if (b_wr) begin
      mem_q[b_addr_i] <= b_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_en_i && !a_we_i) begin
        a_rdata_q <= mem_q[a_addr_i];
      end
      if (b_en_i && !b_we_i) begin
        b_rdata_q <= mem_q[b_addr_i];
      end
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/matrix_mem_responder.sv
// matrix_mem_responder
// Scratchpad memory on the responder side of the matrix engine's
// mem_operation/mem_opdone bus. Each accepted request completes exactly
// LATENCY cycles later with a one-cycle mem_opdone pulse. A host port
// preloads operands and reads results directly from the RAM.
//
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   eng              engine bus (slave modport of matrix_mem_responder_if)
//   err              sticky out-of-range flag, cleared only by reset
//   host_en/host_we  host access strobe / write select
//   host_addr        host word address
//   host_wdata       host write data
//   host_rdata       host read data, one cycle after a host read
//   host_collision   one-cycle pulse, the cycle after a host write was
//                    dropped in favour of a same-address engine write
//   dbg_state_o      current FSM state
//
// LATENCY must lie in 1..15 (4-bit counter).

module matrix_mem_responder
  import matrix_mem_responder_pkg::*;
#(
  parameter int DATA_W  = `TYPE_BW,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  matrix_mem_responder_if.slave    eng,
  output logic                     err,
  input  logic                     host_en,
  input  logic                     host_we,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [DATA_W-1:0]        host_wdata,
  output logic [DATA_W-1:0]        host_rdata,
  output logic                     host_collision,
  output state_e                   dbg_state_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              oor_q, oor_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              coll_q;

  logic              new_tuple;
  logic              accept;
  logic              resp_read;
  logic [DATA_W-1:0] data_out;

  logic              ram_a_en;
  logic              ram_a_we;
  logic [AW-1:0]     ram_a_addr;
  logic [DATA_W-1:0] ram_a_rdata;
  logic              ram_coll;

  // In HOLD a request is only new if op or full address changed; this keeps
  // a master that leaves its inputs parked from being served twice.
  assign new_tuple = (eng.mem_operation != op_q) || (eng.addr_i != addr_q);

  always_comb begin
    accept = 1'b0;
    case (state_q)
      ST_IDLE: accept = is_request(eng.mem_operation);
      ST_HOLD: accept = is_request(eng.mem_operation) && new_tuple;
      default: accept = 1'b0;
    endcase
    accept = accept && reset_n;
  end

  // Next-state and latch logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    oor_d   = oor_q;
    cnt_d   = cnt_q;

    if (accept) begin
      op_d    = eng.mem_operation;
      addr_d  = eng.addr_i;
      wdata_d = eng.data_i;
      // Range check on the full 32-bit address, before truncation.
      oor_d   = (eng.addr_i >= DEPTH_W);
      cnt_d   = CNT_INIT;
      state_d = (LATENCY == 1) ? ST_RESPOND : ST_WAIT;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end
          if (cnt_q <= 4'd1) begin
            state_d = ST_RESPOND;
          end
        end
        ST_RESPOND: state_d = ST_HOLD;
        ST_HOLD: begin
          if (!is_request(eng.mem_operation)) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // The RAM read is registered, so the read is launched on the cycle that
  // enters RESPOND; its data then lines up with the mem_opdone cycle. The
  // address comes straight from the bus when RESPOND follows an accept
  // (LATENCY == 1), otherwise from the latched copy.
  assign ram_a_we   = (state_q == ST_RESPOND) && (op_q == MEM_WRITE) && !oor_q && reset_n;
  assign ram_a_en   = ram_a_we || ((state_d == ST_RESPOND) && reset_n);
  assign ram_a_addr = accept ? eng.addr_i[AW-1:0] : addr_q[AW-1:0];

  dual_port_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk         (clk),
    .reset_n     (reset_n),
    .a_en_i      (ram_a_en),
    .a_we_i      (ram_a_we),
    .a_addr_i    (ram_a_addr),
    .a_wdata_i   (wdata_q),
    .a_rdata_o   (ram_a_rdata),
    .b_en_i      (host_en),
    .b_we_i      (host_we),
    .b_addr_i    (host_addr),
    .b_wdata_i   (host_wdata),
    .b_rdata_o   (host_rdata),
    .collision_o (ram_coll)
  );

  // data_o shows fresh read data in the RESPOND cycle and otherwise holds
  // the last completed read; writes never disturb it.
  assign resp_read = (state_q == ST_RESPOND) && (op_q == MEM_READ);

  always_comb begin
    data_out = rdata_q;
    if (resp_read) begin
      data_out = oor_q ? '0 : ram_a_rdata;
    end
  end

  assign rdata_d = data_out;

  // err rises combinationally in the offending RESPOND cycle and is held
  // by err_q from then on.
  assign err   = err_q || ((state_q == ST_RESPOND) && oor_q);
  assign err_d = err;

  assign eng.data_o     = data_out;
  assign eng.mem_opdone = (state_q == ST_RESPOND);
  assign eng.busy       = accept || (state_q == ST_WAIT) || (state_q == ST_RESPOND);
  assign host_collision = coll_q;
  assign dbg_state_o    = state_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= MEM_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      coll_q  <= ram_coll;
    end
  end

endmodule

// File: tb/tb_matrix_mem_responder.sv
// tb_matrix_mem_responder
// Directed bench for matrix_mem_responder: instance A (LATENCY=2) covers
// read latency, parameter fetch, write/readback, out-of-range, collision and
// read-old-on-write; instance B (LATENCY=4) covers reset mid-request.

module tb_matrix_mem_responder;
  import matrix_mem_responder_pkg::*;

  localparam int DW    = `TYPE_BW;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n_a;
  logic reset_n_b;

  // ---------------- DUT A (LATENCY=2) ----------------
  matrix_mem_responder_if #(.DATA_W(DW)) eng_a ();
  logic          err_a;
  logic          ha_en, ha_we;
  logic [AW-1:0] ha_addr;
  logic [DW-1:0] ha_wdata, ha_rdata;
  logic          ha_coll;
  state_e        st_a;

  matrix_mem_responder #(.DATA_W(DW), .DEPTH(DEPTH), .LATENCY(2)) dut_a (
    .clk            (clk),
    .reset_n        (reset_n_a),
    .eng            (eng_a),
    .err            (err_a),
    .host_en        (ha_en),
    .host_we        (ha_we),
    .host_addr      (ha_addr),
    .host_wdata     (ha_wdata),
    .host_rdata     (ha_rdata),
    .host_collision (ha_coll),
    .dbg_state_o    (st_a)
  );

  // ---------------- DUT B (LATENCY=4) ----------------
  matrix_mem_responder_if #(.DATA_W(DW)) eng_b ();
  logic          err_b;
  logic          hb_en, hb_we;
  logic [AW-1:0] hb_addr;
  logic [DW-1:0] hb_wdata, hb_rdata;
  logic          hb_coll;
  state_e        st_b;

  matrix_mem_responder #(.DATA_W(DW), .DEPTH(DEPTH), .LATENCY(4)) dut_b (
    .clk            (clk),
    .reset_n        (reset_n_b),
    .eng            (eng_b),
    .err            (err_b),
    .host_en        (hb_en),
    .host_we        (hb_we),
    .host_addr      (hb_addr),
    .host_wdata     (hb_wdata),
    .host_rdata     (hb_rdata),
    .host_collision (hb_coll),
    .dbg_state_o    (st_b)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Every completion on A pops one expected data_o value.
  always @(negedge clk) begin
    if (eng_a.mem_opdone === 1'b1) begin
      pulses_a++;
      if (exp_q.size() == 0) check_val("unexpected_pulse_a", 64'd1, 64'd0);
      else check_val("resp_data_a", 64'(eng_a.data_o), 64'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (eng_b.mem_opdone === 1'b1) pulses_b++;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic host_wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ha_en = 1'b1; ha_we = 1'b1; ha_addr = a; ha_wdata = d;
    step();
    ha_en = 1'b0; ha_we = 1'b0;
  endtask

  task automatic host_rd_a(input logic [AW-1:0] a, output logic [DW-1:0] d);
    ha_en = 1'b1; ha_we = 1'b0; ha_addr = a;
    step();
    d = ha_rdata;
    ha_en = 1'b0;
  endtask

  task automatic host_wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
    hb_en = 1'b1; hb_we = 1'b1; hb_addr = a; hb_wdata = d;
    step();
    hb_en = 1'b0; hb_we = 1'b0;
  endtask

  task automatic host_rd_b(input logic [AW-1:0] a, output logic [DW-1:0] d);
    hb_en = 1'b1; hb_we = 1'b0; hb_addr = a;
    step();
    d = hb_rdata;
    hb_en = 1'b0;
  endtask

  task automatic eng_req_a(input logic [1:0] op, input logic [31:0] a, input logic [DW-1:0] d);
    eng_a.mem_operation = op; eng_a.addr_i = a; eng_a.data_i = d;
  endtask

  task automatic eng_req_b(input logic [1:0] op, input logic [31:0] a, input logic [DW-1:0] d);
    eng_b.mem_operation = op; eng_b.addr_i = a; eng_b.data_i = d;
  endtask

  // Returns at the negedge of the pulse cycle; cycles counts negedges
  // waited beyond the first. A timeout is reported as a failed comparison.
  task automatic wait_pulse_a(input string tag, output int cycles);
    bit seen = 1'b0;
    cycles = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (eng_a.mem_opdone === 1'b1) begin
        seen = 1'b1;
        cycles = i;
      end
    end
    check_val(tag, 64'(seen), 64'd1);
  endtask

  task automatic wait_pulse_b(input string tag, output int cycles);
    bit seen = 1'b0;
    cycles = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (eng_b.mem_opdone === 1'b1) begin
        seen = 1'b1;
        cycles = i;
      end
    end
    check_val(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] d;
    int cyc;
    int p0;
    int fetch_vals [5];

    reset_n_a = 1'b0; reset_n_b = 1'b0;
    ha_en = 1'b0; ha_we = 1'b0; ha_addr = '0; ha_wdata = '0;
    hb_en = 1'b0; hb_we = 1'b0; hb_addr = '0; hb_wdata = '0;
    eng_req_a(MEM_NONE, 32'd0, '0);
    eng_req_b(MEM_NONE, 32'd0, '0);
    step(3);

    // Reset state
    check_val("rst_opdone", 64'(eng_a.mem_opdone), 64'd0);
    check_val("rst_busy",   64'(eng_a.busy),       64'd0);
    check_val("rst_err",    64'(err_a),            64'd0);
    check_val("rst_data_o", 64'(eng_a.data_o),     64'd0);
    check_val("rst_hrdata", 64'(ha_rdata),         64'd0);
    check_val("rst_coll",   64'(ha_coll),          64'd0);
    check_val("rst_state",  64'(st_a),             64'(ST_IDLE));
    reset_n_a = 1'b1; reset_n_b = 1'b1;
    step();

    // Read latency: pulse only at t+2, busy over t..t+2
    host_wr_a(10'd5, DW'('hAB));
    exp_q.push_back(DW'('hAB));
    eng_req_a(MEM_READ, 32'd5, '0);
    @(negedge clk);
    check_val("lat_t_busy", 64'(eng_a.busy), 64'd1);
    check_val("lat_t_done", 64'(eng_a.mem_opdone), 64'd0);
    @(negedge clk);
    check_val("lat_t1_busy", 64'(eng_a.busy), 64'd1);
    check_val("lat_t1_done", 64'(eng_a.mem_opdone), 64'd0);
    @(negedge clk);
    check_val("lat_t2_done", 64'(eng_a.mem_opdone), 64'd1);
    check_val("lat_t2_data", 64'(eng_a.data_o), 64'hAB);
    check_val("lat_t2_busy", 64'(eng_a.busy), 64'd1);
    eng_req_a(MEM_NONE, 32'd5, '0);
    @(negedge clk);
    check_val("lat_t3_done", 64'(eng_a.mem_opdone), 64'd0);
    check_val("lat_t3_busy", 64'(eng_a.busy), 64'd0);
    @(posedge clk); #1;

    // Parameter fetch: hold op=read, step address on each pulse
    fetch_vals = '{2, 3, 3, 2, 'h55};
    host_wr_a(10'(PARAM_WIDTH_A),  DW'(2));
    host_wr_a(10'(PARAM_HEIGHT_A), DW'(3));
    host_wr_a(10'(PARAM_WIDTH_B),  DW'(3));
    host_wr_a(10'(PARAM_HEIGHT_B), DW'(2));
    host_wr_a(10'd4, DW'('h55));
    for (int k = 0; k < 5; k++) exp_q.push_back(DW'(fetch_vals[k]));
    p0 = pulses_a;
    eng_req_a(MEM_READ, 32'd0, '0);
    for (int k = 0; k < 5; k++) begin
      wait_pulse_a("fetch_pulse", cyc);
      if (k < 4) eng_a.addr_i = 32'(k + 1);
    end
    step(6);
    check_val("fetch_pulse_cnt", 64'(pulses_a - p0), 64'd5);
    eng_req_a(MEM_NONE, 32'd4, '0);
    step(2);

    // Write then host readback; data_o keeps the last read value
    exp_q.push_back(DW'('h55));
    p0 = pulses_a;
    eng_req_a(MEM_WRITE, 32'd20, DW'('h1234));
    wait_pulse_a("wr_pulse", cyc);
    eng_req_a(MEM_NONE, 32'd20, '0);
    @(posedge clk); #1;
    step(3);
    check_val("wr_one_pulse", 64'(pulses_a - p0), 64'd1);
    host_rd_a(10'd20, d);
    check_val("wr_host_rd", 64'(d), 64'h1234);

    // Out-of-range read and write
    exp_q.push_back('0);
    eng_req_a(MEM_READ, 32'd2000, '0);
    wait_pulse_a("oor_rd_pulse", cyc);
    check_val("oor_err_resp", 64'(err_a), 64'd1);
    eng_req_a(MEM_NONE, 32'd0, '0);
    @(posedge clk); #1;
    step(2);
    check_val("oor_err_sticky", 64'(err_a), 64'd1);
    exp_q.push_back('0);
    eng_req_a(MEM_WRITE, 32'd4096, DW'('hDEAD));
    wait_pulse_a("oor_wr_pulse", cyc);
    eng_req_a(MEM_NONE, 32'd0, '0);
    @(posedge clk); #1;
    host_rd_a(10'd0, d);
    check_val("oor_wr_mem0", 64'(d), 64'd2);

    // Collision: engine and host write addr 7 on the same edge
    exp_q.push_back('0);
    eng_req_a(MEM_WRITE, 32'd7, DW'('h11));
    step(2);
    ha_en = 1'b1; ha_we = 1'b1; ha_addr = 10'd7; ha_wdata = DW'('h22);
    @(negedge clk);
    check_val("coll_align", 64'(eng_a.mem_opdone), 64'd1);
    check_val("coll_pre", 64'(ha_coll), 64'd0);
    eng_req_a(MEM_NONE, 32'd0, '0);
    @(posedge clk); #1;
    ha_en = 1'b0; ha_we = 1'b0;
    check_val("coll_pulse", 64'(ha_coll), 64'd1);
    step();
    check_val("coll_clear", 64'(ha_coll), 64'd0);
    host_rd_a(10'd7, d);
    check_val("coll_mem7", 64'(d), 64'h11);

    // Host read of an address the engine writes on the same edge
    host_wr_a(10'd9, DW'('h77));
    exp_q.push_back('0);
    eng_req_a(MEM_WRITE, 32'd9, DW'('h99));
    step(2);
    ha_en = 1'b1; ha_we = 1'b0; ha_addr = 10'd9;
    @(negedge clk);
    eng_req_a(MEM_NONE, 32'd0, '0);
    @(posedge clk); #1;
    ha_en = 1'b0;
    check_val("rd_old_value", 64'(ha_rdata), 64'h77);
    host_rd_a(10'd9, d);
    check_val("rd_new_value", 64'(d), 64'h99);

    // B: read with LATENCY=4, then reset in WAIT during a write
    host_wr_b(10'd30, DW'('h5A));
    host_rd_b(10'd30, d);
    check_val("b_host_rd", 64'(d), 64'h5A);
    eng_req_b(MEM_READ, 32'd30, '0);
    wait_pulse_b("b_rd_pulse", cyc);
    check_val("b_rd_latency", 64'(cyc), 64'd4);
    check_val("b_rd_data", 64'(eng_b.data_o), 64'h5A);
    eng_req_b(MEM_NONE, 32'd0, '0);
    @(posedge clk); #1;
    step();
    eng_req_b(MEM_WRITE, 32'd30, DW'('hBAD));
    step(2);
    check_val("b_in_wait", 64'(st_b), 64'(ST_WAIT));
    reset_n_b = 1'b0;
    eng_req_b(MEM_NONE, 32'd0, '0);
    p0 = pulses_b;
    step();
    check_val("b_rst_done",   64'(eng_b.mem_opdone), 64'd0);
    check_val("b_rst_busy",   64'(eng_b.busy),       64'd0);
    check_val("b_rst_data_o", 64'(eng_b.data_o),     64'd0);
    check_val("b_rst_err",    64'(err_b),            64'd0);
    check_val("b_rst_hrdata", 64'(hb_rdata),         64'd0);
    check_val("b_rst_coll",   64'(hb_coll),          64'd0);
    check_val("b_rst_state",  64'(st_b),             64'(ST_IDLE));
    reset_n_b = 1'b1;
    step(6);
    check_val("b_no_pulse", 64'(pulses_b - p0), 64'd0);
    host_rd_b(10'd30, d);
    check_val("b_wr_dropped", 64'(d), 64'h5A);
    eng_req_b(MEM_READ, 32'd30, '0);
    wait_pulse_b("b_post_rst_pulse", cyc);
    check_val("b_post_rst_lat", 64'(cyc), 64'd4);
    check_val("b_post_rst_data", 64'(eng_b.data_o), 64'h5A);
    eng_req_b(MEM_NONE, 32'd0, '0);
    @(posedge clk); #1;
    step(2);

    check_val("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
